// File: rtl/mips_cpu_muldiv_if.sv
// Request/result bundle between execute control and the HI/LO multiply/divide unit.
interface mips_cpu_muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_muldiv.sv
// MIPS-I multiply/divide unit: 32-step shift-add / restoring divide with HI/LO.
// Optional MIPS_CPU_MULDIV_FAST_MULT_EN: single-cycle multiply, divide unchanged.
module mips_cpu_muldiv (
  input  logic               clk,
  input  logic               reset,
  mips_cpu_muldiv_if.slave   bus
);
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [4:0]  cnt;
  // MUL: {partial sum, remaining multiplier}; DIV: {remainder, dividend/quotient}
  logic [63:0] acc;
  logic [31:0] mcand;
  logic [31:0] a_raw;
  logic        is_div, b_zero, neg_res, neg_rem;

  logic        signed_op;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] q_fix, r_fix;

  always_comb begin
    signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    abs_a     = (signed_op && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
    abs_b     = (signed_op && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
    mul_next  = {mul_sum, acc[31:1]};
    div_sh    = {acc[63:32], acc[31]};
    div_ge    = div_sh >= {1'b0, mcand};
    // when div_ge the true difference is below 2^32, so the low word is exact
    div_rem   = div_ge ? (div_sh[31:0] - mcand) : div_sh[31:0];
    div_next  = {div_rem, acc[30:0], div_ge};
    prod_fix  = neg_res ? (~acc + 64'd1) : acc;
    q_fix     = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
    r_fix     = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
  logic [63:0] ext_a, ext_b, fast_prod;
  always_comb begin
    ext_a     = signed_op ? {{32{bus.a[31]}}, bus.a} : {32'd0, bus.a};
    ext_b     = signed_op ? {{32{bus.b[31]}}, bus.b} : {32'd0, bus.b};
    fast_prod = ext_a * ext_b;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      a_raw   <= '0;
      is_div  <= 1'b0;
      b_zero  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
              OP_MULT, OP_MULTU: begin
                hi   <= fast_prod[63:32];
                lo   <= fast_prod[31:0];
                done <= 1'b1;
              end
`else
              OP_MULT, OP_MULTU: begin
                state   <= MUL;
                busy    <= 1'b1;
                cnt     <= '0;
                acc     <= {32'd0, abs_b};
                mcand   <= abs_a;
                is_div  <= 1'b0;
                neg_res <= signed_op && (bus.a[31] ^ bus.b[31]);
                neg_rem <= 1'b0;
              end
`endif
              OP_DIV, OP_DIVU: begin
                state   <= DIV;
                busy    <= 1'b1;
                cnt     <= '0;
                acc     <= {32'd0, abs_a};
                mcand   <= abs_b;
                a_raw   <= bus.a;
                is_div  <= 1'b1;
                b_zero  <= (bus.b == 32'd0);
                neg_res <= signed_op && (bus.a[31] ^ bus.b[31]);
                neg_rem <= signed_op && bus.a[31];
              end
              OP_MTHI: begin
                hi   <= bus.a;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= bus.a;
                done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end else if (b_zero) begin
            hi <= a_raw;
            lo <= 32'hFFFF_FFFF;
          end else begin
            hi <= r_fix;
            lo <= q_fix;
          end
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.hi   = hi;
  assign bus.lo   = lo;
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv: results, latency, busy-ignore, reserved op, reset abort.
module tb_mips_cpu_muldiv;
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mips_cpu_muldiv_if bus ();
  mips_cpu_muldiv dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op in the current cycle and wait for its done pulse.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] ai,
                        input logic [31:0] bi, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_lat);
    logic [31:0] old_hi, old_lo;
    int lat;
    logic held;
    old_hi = bus.hi;
    old_lo = bus.lo;
    bus.start = 1'b1; bus.op = o; bus.a = ai; bus.b = bi;
    step();
    bus.start = 1'b0;
    check({tag, "_busy"}, 64'(bus.busy), 64'(exp_lat > 1));
    lat = 1;
    held = 1'b1;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.hi !== old_hi || bus.lo !== old_lo) held = 1'b0;
      step();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    if (exp_lat > 1) check({tag, "_held"}, 64'(held), 64'd1);
  endtask

  initial begin
    int lat;
    int ndone;
    bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
    step();
    step();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;
    step();

    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
    run_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
    run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    run_op("divu", 3'b011, 32'd7, 32'd2, 32'd1, 32'd3, DIV_LAT);
    run_op("div_zero", 3'b010, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DIV_LAT);
    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT);
    run_op("mthi", 3'b100, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'h8000_0000, 1);
    run_op("mtlo", 3'b101, 32'h0000_0055, 32'd0, 32'h0000_1234, 32'h0000_0055, 1);

    // DIVU 100/7 with a DIV 1/1 pulsed at N+5 while busy
    bus.start = 1'b1; bus.op = 3'b011; bus.a = 32'd100; bus.b = 32'd7;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd1; bus.b = 32'd1;
    step();
    bus.start = 1'b0;
    lat = 6;
    while (bus.done !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    check("busy_ign_lat", 64'(lat), 64'd34);
    check("busy_ign_hi", 64'(bus.hi), 64'd2);
    check("busy_ign_lo", 64'(bus.lo), 64'd14);
    ndone = 0;
    repeat (40) begin
      step();
      if (bus.done === 1'b1) ndone++;
    end
    check("busy_ign_nodone", 64'(ndone), 64'd0);

    // reserved op: no done, no busy, hi/lo untouched
    bus.start = 1'b1; bus.op = 3'b110; bus.a = 32'hDEAD_BEEF; bus.b = 32'd3;
    step();
    bus.start = 1'b0;
    check("rsv_busy", 64'(bus.busy), 64'd0);
    ndone = 0;
    repeat (5) begin
      if (bus.done === 1'b1) ndone++;
      step();
    end
    check("rsv_nodone", 64'(ndone), 64'd0);
    check("rsv_hi", 64'(bus.hi), 64'd2);
    check("rsv_lo", 64'(bus.lo), 64'd14);

    // reset at N+10 of a DIVU
    bus.start = 1'b1; bus.op = 3'b011; bus.a = 32'd50; bus.b = 32'd3;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    check("abort_busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    step();
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      step();
      if (bus.done === 1'b1) ndone++;
    end
    check("abort_nodone", 64'(ndone), 64'd0);
    run_op("multu_small", 3'b001, 32'd3, 32'd4, 32'd0, 32'd12, MUL_LAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
